// File: rtl/mem_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mem_arbiter
// Purpose  : Shares the single-port LC-3 main memory between the CPU memory
//            interface (MAR/MDR path) and the debug/program-loader port.
//            Each granted access holds mem_en_o for WAIT_CYCLES cycles, then
//            returns a one-cycle completion strobe to the winner (cpu_r_o,
//            sampled by the microsequencer as R, or dbg_ack_o).
// Ports    : clk, reset          - clock, synchronous active-high reset
//            cpu_*_i / cpu_*_o   - CPU request, write enable, address, write
//                                  data, read data and ready strobe
//            dbg_*_i / dbg_*_o   - debug request, write enable, address, write
//                                  data, read data and ack strobe
//            dbg_hold_i          - blocks CPU grants while high
//            mem_*_o / mem_*_i   - memory array enable, write enable, address,
//                                  write data and read data
//            busy_o              - high while an access is in flight
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic [DATA_W-1:0] cpu_rdata_o,
   output logic              cpu_r_o,
   input  logic              dbg_req_i,
   input  logic              dbg_we_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   input  logic [DATA_W-1:0] dbg_wdata_i,
   output logic [DATA_W-1:0] dbg_rdata_o,
   output logic              dbg_ack_o,
   input  logic              dbg_hold_i,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              busy_o
);

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                gnt_dbg_q, gnt_dbg_d;    // owner of the current access
   logic                last_dbg_q, last_dbg_d;  // round-robin pointer, 1 = DBG
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
   logic                cpu_r_q, cpu_r_d;
   logic                dbg_ack_q, dbg_ack_d;
   logic                busy_q, busy_d;

   logic                cpu_cand, dbg_cand, pick_dbg;

   // CPU is only eligible while the debugger is not holding it off. On a tie,
   // the requester that did not win last time goes next.
   assign cpu_cand = cpu_req_i & ~dbg_hold_i;
   assign dbg_cand = dbg_req_i;
   assign pick_dbg = (cpu_cand & dbg_cand) ? ~last_dbg_q : dbg_cand;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      gnt_dbg_d   = gnt_dbg_q;
      last_dbg_d  = last_dbg_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dbg_rdata_d = dbg_rdata_q;
      cpu_r_d     = 1'b0;
      dbg_ack_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (cpu_cand | dbg_cand) begin
               gnt_dbg_d   = pick_dbg;
               last_dbg_d  = pick_dbg;
               mem_addr_d  = pick_dbg ? dbg_addr_i  : cpu_addr_i;
               mem_wdata_d = pick_dbg ? dbg_wdata_i : cpu_wdata_i;
               mem_we_d    = pick_dbg ? dbg_we_i    : cpu_we_i;
               mem_en_d    = 1'b1;
               cnt_d       = CNT_LOAD;
               state_d     = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q == 4'd0) begin
               // Last enabled cycle: capture read data for the owner only on
               // reads so a write leaves the previous read value intact.
               if (!mem_we_q) begin
                  if (gnt_dbg_q) begin
                     dbg_rdata_d = mem_rdata_i;
                  end else begin
                     cpu_rdata_d = mem_rdata_i;
                  end
               end
               mem_en_d  = 1'b0;
               mem_we_d  = 1'b0;
               cpu_r_d   = ~gnt_dbg_q;
               dbg_ack_d = gnt_dbg_q;
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         gnt_dbg_q   <= 1'b0;
         last_dbg_q  <= 1'b1;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
         cpu_r_q     <= 1'b0;
         dbg_ack_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gnt_dbg_q   <= gnt_dbg_d;
         last_dbg_q  <= last_dbg_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
         cpu_r_q     <= cpu_r_d;
         dbg_ack_q   <= dbg_ack_d;
         busy_q      <= busy_d;
      end
   end

   assign cpu_rdata_o = cpu_rdata_q;
   assign cpu_r_o     = cpu_r_q;
   assign dbg_rdata_o = dbg_rdata_q;
   assign dbg_ack_o   = dbg_ack_q;
   assign mem_en_o    = mem_en_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter. A WAIT_CYCLES=2
//            instance drives a behavioural memory; a WAIT_CYCLES=1 instance
//            reads from an address-derived pattern.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_hold;
   logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
   logic [15:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        cpu_r, dbg_ack, mem_en, mem_we, busy;

   // second instance, WAIT_CYCLES = 1
   logic        c1_req, c1_we, d1_req, d1_we, d1_hold;
   logic [15:0] c1_addr, c1_wdata, d1_addr, d1_wdata;
   logic [15:0] c1_rdata, d1_rdata, m1_addr, m1_wdata, m1_rdata;
   logic        c1_r, d1_ack, m1_en, m1_we, busy1;

   // preload port into the behavioural memory
   logic        pl_we;
   logic [15:0] pl_addr, pl_data;
   logic [15:0] mem [0:65535];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
      else if (pl_we)       mem[pl_addr]  <= pl_data;
   end
   assign mem_rdata = mem[mem_addr];
   assign m1_rdata  = m1_addr ^ 16'hFFFF;

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(2)) u_dut (
      .clk(clk), .reset(reset),
      .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
      .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_r_o(cpu_r),
      .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
      .dbg_wdata_i(dbg_wdata), .dbg_rdata_o(dbg_rdata), .dbg_ack_o(dbg_ack),
      .dbg_hold_i(dbg_hold),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy)
   );

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .cpu_req_i(c1_req), .cpu_we_i(c1_we), .cpu_addr_i(c1_addr),
      .cpu_wdata_i(c1_wdata), .cpu_rdata_o(c1_rdata), .cpu_r_o(c1_r),
      .dbg_req_i(d1_req), .dbg_we_i(d1_we), .dbg_addr_i(d1_addr),
      .dbg_wdata_i(d1_wdata), .dbg_rdata_o(d1_rdata), .dbg_ack_o(d1_ack),
      .dbg_hold_i(d1_hold),
      .mem_en_o(m1_en), .mem_we_o(m1_we), .mem_addr_o(m1_addr),
      .mem_wdata_o(m1_wdata), .mem_rdata_i(m1_rdata), .busy_o(busy1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      int hits;
      int got;
      reset = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_hold = 0;
      c1_req = 0; c1_we = 0; c1_addr = 0; c1_wdata = 0;
      d1_req = 0; d1_we = 0; d1_addr = 0; d1_wdata = 0; d1_hold = 0;
      pl_we = 1'b1; pl_addr = 16'h3000; pl_data = 16'h1234;
      step();
      pl_we = 1'b0;
      step();

      // reset state
      chk("rst_mem_en",   {31'd0, mem_en},  32'd0);
      chk("rst_cpu_r",    {31'd0, cpu_r},   32'd0);
      chk("rst_dbg_ack",  {31'd0, dbg_ack}, 32'd0);
      chk("rst_busy",     {31'd0, busy},    32'd0);
      chk("rst_cpu_rdata", {16'd0, cpu_rdata}, 32'h0);
      chk("rst_dbg_rdata", {16'd0, dbg_rdata}, 32'h0);
      chk("rst_mem_addr",  {16'd0, mem_addr},  32'h0);

      reset = 1'b0;
      step();

      // CPU read of 0x3000
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
      step();
      chk("rd_en_c1",   {31'd0, mem_en}, 32'd1);
      chk("rd_addr",    {16'd0, mem_addr}, 32'h3000);
      chk("rd_we",      {31'd0, mem_we}, 32'd0);
      chk("rd_busy",    {31'd0, busy},   32'd1);
      chk("rd_r_early", {31'd0, cpu_r},  32'd0);
      step();
      chk("rd_en_c2",   {31'd0, mem_en}, 32'd1);
      chk("rd_r_early2", {31'd0, cpu_r}, 32'd0);
      step();
      chk("rd_en_off",  {31'd0, mem_en}, 32'd0);
      chk("rd_cpu_r",   {31'd0, cpu_r},  32'd1);
      chk("rd_dbg_ack", {31'd0, dbg_ack}, 32'd0);
      chk("rd_rdata",   {16'd0, cpu_rdata}, 32'h1234);
      cpu_req = 0;
      step();
      chk("rd_r_drop",  {31'd0, cpu_r}, 32'd0);
      chk("rd_idle",    {31'd0, busy},  32'd0);

      // debug write 0xBEEF to 0x4000
      dbg_req = 1; dbg_we = 1; dbg_addr = 16'h4000; dbg_wdata = 16'hBEEF;
      step();
      chk("wr_en",    {31'd0, mem_en}, 32'd1);
      chk("wr_we",    {31'd0, mem_we}, 32'd1);
      chk("wr_addr",  {16'd0, mem_addr},  32'h4000);
      chk("wr_wdata", {16'd0, mem_wdata}, 32'hBEEF);
      step();
      chk("wr_we2",   {31'd0, mem_we}, 32'd1);
      chk("wr_ack_early", {31'd0, dbg_ack}, 32'd0);
      step();
      chk("wr_ack",   {31'd0, dbg_ack}, 32'd1);
      chk("wr_we_off", {31'd0, mem_we}, 32'd0);
      chk("wr_cpu_r", {31'd0, cpu_r},  32'd0);
      chk("wr_rdata_hold", {16'd0, dbg_rdata}, 32'h0);
      dbg_req = 0; dbg_we = 0;
      step();
      chk("wr_ack_drop", {31'd0, dbg_ack}, 32'd0);

      // CPU read-back of 0x4000
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h4000;
      step(); step(); step();
      chk("rb_cpu_r", {31'd0, cpu_r}, 32'd1);
      chk("rb_rdata", {16'd0, cpu_rdata}, 32'hBEEF);
      cpu_req = 0;
      step();
      chk("rb_rdata_hold", {16'd0, cpu_rdata}, 32'hBEEF);

      // simultaneous requests held from reset: CPU, DBG, CPU, DBG
      reset = 1;
      cpu_req = 1; cpu_addr = 16'h3000;
      dbg_req = 1; dbg_we = 0; dbg_addr = 16'h4000;
      step();
      reset = 0;
      for (int k = 0; k < 4; k++) begin
         hits = 0;
         while (!(cpu_r || dbg_ack) && hits < 10) begin
            step();
            hits++;
         end
         chk("rr_timeout", {31'd0, (hits < 10)}, 32'd1);
         got = dbg_ack ? 1 : 0;
         chk("rr_order", got, (k % 2 == 1) ? 32'd1 : 32'd0);
         chk("rr_excl",  {31'd0, (cpu_r & dbg_ack)}, 32'd0);
         if (k == 3) begin
            cpu_req = 0; dbg_req = 0;
         end
         step();
         chk("rr_single", {30'd0, cpu_r, dbg_ack}, 32'd0);
      end
      chk("rr_cpu_rdata", {16'd0, cpu_rdata}, 32'h1234);
      chk("rr_dbg_rdata", {16'd0, dbg_rdata}, 32'hBEEF);

      // dbg_hold blocks the CPU
      dbg_hold = 1; cpu_req = 1; cpu_addr = 16'h3000;
      hits = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (cpu_r || mem_en) hits++;
      end
      chk("hold_blocked", hits, 32'd0);
      dbg_hold = 0;
      step();
      chk("hold_rel_en", {31'd0, mem_en}, 32'd1);
      step();
      chk("hold_rel_r_early", {31'd0, cpu_r}, 32'd0);
      step();
      chk("hold_rel_r", {31'd0, cpu_r}, 32'd1);
      cpu_req = 0;
      step();

      // reset in first ACCESS cycle of a CPU write
      cpu_req = 1; cpu_we = 1; cpu_addr = 16'h5000; cpu_wdata = 16'hAAAA;
      step();
      chk("ab_en", {31'd0, mem_en}, 32'd1);
      reset = 1; dbg_req = 1; dbg_we = 0; dbg_addr = 16'h4000;
      step();
      chk("ab_en_off", {31'd0, mem_en}, 32'd0);
      chk("ab_busy",   {31'd0, busy},   32'd0);
      chk("ab_no_r",   {31'd0, cpu_r},  32'd0);
      reset = 0;
      step();
      chk("ab_regrant_addr", {16'd0, mem_addr}, 32'h5000);
      chk("ab_regrant_we",   {31'd0, mem_we},   32'd1);
      step();
      chk("ab_no_r2", {31'd0, cpu_r}, 32'd0);
      step();
      chk("ab_cpu_r",  {31'd0, cpu_r},   32'd1);
      chk("ab_dbg_ack", {31'd0, dbg_ack}, 32'd0);
      cpu_req = 0; cpu_we = 0; dbg_req = 0;
      step();

      // WAIT_CYCLES = 1, back-to-back CPU reads: period of 3 cycles
      c1_req = 1; c1_we = 0; c1_addr = 16'h0010;
      hits = 0;
      got = 0;
      for (int i = 1; i <= 9; i++) begin
         step();
         chk("w1_en", {31'd0, m1_en}, (i % 3 == 1) ? 32'd1 : 32'd0);
         chk("w1_r",  {31'd0, c1_r},  (i % 3 == 2) ? 32'd1 : 32'd0);
      end
      chk("w1_rdata", {16'd0, c1_rdata}, 32'hFFEF);
      c1_req = 0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port LC-3 main memory between two requesters: the CPU memory interface (MAR/MDR path) and the debug/program-loader port.
- Sequences each access through a fixed wait-state counter.
- Returns a one-cycle ready strobe (cpu_r) that the microsequencer samples as R in its memory wait states.
- Sits between the control/datapath and the memory array.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- WAIT_CYCLES, 2, cycles mem_en is held per access (legal range 1..15)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cpu_req  in  1  CPU access request, level, held until cpu_r
- cpu_we  in  1  CPU write enable, 1 = write
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  CPU read data, valid when cpu_r = 1
- cpu_r  out  1  CPU ready strobe
- dbg_req  in  1  debug request, level, held until dbg_ack
- dbg_we  in  1  debug write enable
- dbg_addr  in  ADDR_W  debug address
- dbg_wdata  in  DATA_W  debug write data
- dbg_rdata  out  DATA_W  debug read data, valid when dbg_ack = 1
- dbg_ack  out  1  debug completion strobe
- dbg_hold  in  1  when 1, CPU requests are not granted
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  1 when the FSM is not in IDLE

Behaviour:
- FSM states: IDLE, ACCESS, DONE. All outputs are registered.
- Reset values: state IDLE, all strobes/enables 0, cpu_rdata and dbg_rdata 0, mem_addr and mem_wdata 0, wait counter 0, last-grant pointer = DBG (so the CPU wins the first tie).
- IDLE, candidate set:
  - cpu_req is a candidate only when dbg_hold = 0.
  - dbg_req is always a candidate.
  - No candidate: stay in IDLE.
- IDLE, arbitration:
  - One candidate: grant it.
  - Both candidates: grant the one not equal to the last-grant pointer (round-robin).
- IDLE, on grant:
  - Latch addr, wdata and we of the winner into mem_addr, mem_wdata and mem_we.
  - Set mem_en = 1 and the counter to WAIT_CYCLES-1.
  - Update the pointer and go to ACCESS.
- ACCESS:
  - mem_en, mem_we, mem_addr and mem_wdata stay stable.
  - Counter decrements each cycle.
  - In the cycle the counter = 0: sample mem_rdata into the granted requester's rdata register (reads only; on writes the rdata register holds its old value), drop mem_en and mem_we, and go to DONE.
- DONE:
  - Assert cpu_r or dbg_ack, whichever is granted, for exactly one cycle, then return to IDLE.
  - The non-granted strobe stays 0.
- Latency:
  - Request seen in IDLE at edge t.
  - mem_en is high for exactly WAIT_CYCLES cycles.
  - The strobe is high in cycle t+WAIT_CYCLES+1.
  - Minimum gap between accesses is one IDLE cycle.
- Requester rule: deassert req in the cycle after the strobe. A req still high in IDLE is treated as a new request.
- Request inputs are ignored outside IDLE. A request dropped mid-access does not abort the access.
- rdata registers hold their value until overwritten by the next read for that requester.
- dbg_hold:
  - Sampled only in IDLE.
  - Asserting it during a CPU access does not abort that access.
  - While held, CPU requests wait indefinitely and cpu_r stays 0.
- Reset mid-operation: at the next edge return to IDLE with mem_en = 0 and no strobe. The aborted access produces no ack.
- busy = 1 in ACCESS and DONE.

Test Plan:
- CPU read, WAIT_CYCLES = 2: mem holds 0x1234 at 0x3000; cpu_req with addr 0x3000, we 0 -> mem_en high for 2 cycles with mem_addr 0x3000, cpu_r pulses 1 cycle, 3 cycles after the request edge, cpu_rdata = 0x1234, dbg_ack = 0.
- Debug write then CPU read-back: dbg writes 0xBEEF to 0x4000 -> dbg_ack one pulse, mem_we high only during ACCESS. CPU then reads 0x4000 -> cpu_rdata = 0xBEEF.
- Simultaneous requests: both req held from reset, each re-requesting immediately after its strobe -> grant order CPU, DBG, CPU, DBG; every strobe is a single cycle.
- dbg_hold = 1 with cpu_req high for 20 cycles -> cpu_r never asserts and mem_en stays 0 (no debug traffic). Release hold -> cpu_r 3 cycles later.
- Reset in the 1st ACCESS cycle of a CPU write -> next cycle state IDLE, mem_en = 0, cpu_r stays 0, busy = 0. Next simultaneous request grants the CPU.
- WAIT_CYCLES = 1 back-to-back CPU reads -> strobe every 3 cycles, mem_en high exactly 1 cycle per access.
